// File: rtl/pwm_axil_pkg.sv
// Shared constants and FSM state types for the PWM AXI4-Lite register block.
package pwm_axil_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_PERIOD  = 4'h4;
    localparam logic [3:0] ADDR_DUTY    = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH = 4'hC;

    // Register index as decoded from byte address bits [3:2].
    localparam logic [1:0] IDX_CTRL    = ADDR_CTRL[3:2];
    localparam logic [1:0] IDX_PERIOD  = ADDR_PERIOD[3:2];
    localparam logic [1:0] IDX_DUTY    = ADDR_DUTY[3:2];
    localparam logic [1:0] IDX_SCRATCH = ADDR_SCRATCH[3:2];

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_INVERT_BIT = 1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/pwm_axil_regs_pwm_core.sv
// PWM generator: free-running counter with period/duty shadows that only
// change at period boundaries or when the generator is (re)enabled.
module pwm_core #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          invert,
    input  logic [DW-1:0] period,
    input  logic [DW-1:0] duty,
    output logic          pwm_out
);

    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] period_sh_q, period_sh_d;
    logic [DW-1:0] duty_sh_q, duty_sh_d;
    logic          enable_q;
    logic          pwm_q, pwm_d;

    logic          start;
    logic          reload;
    logic          raw;
    logic [DW-1:0] period_eff;
    logic [DW-1:0] duty_eff;

    always_comb begin
        start      = enable & ~enable_q;
        // On the enable edge the live registers are used directly so the
        // very first period already runs with the programmed values.
        period_eff = start ? period : period_sh_q;
        duty_eff   = start ? duty   : duty_sh_q;
        raw        = 1'b0;
        reload     = 1'b0;
        count_d    = '0;
        if (enable) begin
            if (period_eff == '0) begin
                reload = 1'b1;
            end else begin
                raw = (count_q < duty_eff);
                if (start || (count_q >= period_eff - DW'(1))) begin
                    reload = 1'b1;
                end
                if (count_q >= period_eff - DW'(1)) begin
                    count_d = '0;
                end else begin
                    count_d = count_q + DW'(1);
                end
            end
        end
        period_sh_d = reload ? period : period_sh_q;
        duty_sh_d   = reload ? duty   : duty_sh_q;
        pwm_d       = raw ^ invert;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            enable_q    <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            enable_q    <= enable;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_axil_regs.sv
// AXI4-Lite slave holding CTRL/PERIOD/DUTY/SCRATCH and driving the PWM pin.
// Write and read channels are independent FSMs so neither stalls the other.
module pwm_axil_regs
    import pwm_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            pwm_out
);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                                         wr_hs;
    logic                                         rd_hs;
    logic [1:0]                                   waddr_idx;
    logic [1:0]                                   raddr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]                wr_mask;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  regs;
    logic [C_S_AXI_DATA_WIDTH-1:0]                rdata_q, rdata_d;

    logic unused_sig;
    assign unused_sig = ^{s_axi_awprot, s_axi_arprot,
                          s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign waddr_idx = s_axi_awaddr[3:2];
    assign raddr_idx = s_axi_araddr[3:2];

    genvar gi;
    for (gi = 0; gi < C_S_AXI_DATA_WIDTH / 8; gi++) begin : g_lane
        assign wr_mask[8*gi +: 8] = {8{s_axi_wstrb[gi]}};
    end

    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [C_S_AXI_DATA_WIDTH-1:0] reg_q, reg_d;

        always_comb begin
            reg_d = reg_q;
            if (wr_hs && (waddr_idx == 2'(gi))) begin
                reg_d = (reg_q & ~wr_mask) | (s_axi_wdata & wr_mask);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[gi] = reg_q;
    end

    // Write channel: AW and W are only accepted together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_state_d = W_RESP;
            W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_hs         = (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
        s_axi_awready = wr_hs;
        s_axi_wready  = wr_hs;
        s_axi_bvalid  = (w_state_q == W_RESP);
        s_axi_bresp   = AXI_RESP_OKAY;
    end

    // Read channel: rdata samples the registers before a same-cycle write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid) begin
                r_state_d = R_DATA;
                rdata_d   = regs[raddr_idx];
            end
            R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_hs         = (r_state_q == R_IDLE) && s_axi_arvalid;
        s_axi_arready = rd_hs;
        s_axi_rvalid  = (r_state_q == R_DATA);
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = AXI_RESP_OKAY;
    end

    pwm_core #(
        .DW(C_S_AXI_DATA_WIDTH)
    ) u_pwm_core (
        .clock   (clock),
        .reset   (reset),
        .enable  (regs[IDX_CTRL][CTRL_ENABLE_BIT]),
        .invert  (regs[IDX_CTRL][CTRL_INVERT_BIT]),
        .period  (regs[IDX_PERIOD]),
        .duty    (regs[IDX_DUTY]),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_pwm_axil_regs.sv
// Self-checking bench for pwm_axil_regs: register map, AXI handshakes,
// backpressure, and PWM waveform against a period/duty formula model.
module tb_pwm_axil_regs;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        pwm_out;

    localparam int NEVER = 32'h3fff_ffff;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_hs = 0;
    logic [31:0] model [4];
    logic        pwm_log [8192];

    pwm_axil_regs dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .pwm_out       (pwm_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // pwm_log[x] holds the pin level during cycle x.
    always @(negedge clock) pwm_log[cyc[12:0]] <= pwm_out;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Period 10 waveform enabled in cycle en; invert on from cycle inv_on;
    // DUTY became 7 in cycle duty7_on (3 before). Duty is latched at period start.
    function automatic logic exp_pwm(input int x, input int en, input int inv_on,
                                     input int duty7_on);
        int y, ph, s, d;
        logic inv;
        y   = x - 1;
        ph  = (y - en) % 10;
        s   = y - ph;
        d   = (s > en && s - 1 >= duty7_on) ? 7 : 3;
        inv = (y >= inv_on);
        return (ph < d) ^ inv;
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output bit ok, output bit lat_ok);
        @(posedge clock); #1;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        ok = 1'b0; lat_ok = 1'b0; resp = 2'b11;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_awready && s_axi_wready) begin
                ok = 1'b1;
                last_hs = cyc;
            end
        end
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (ok) begin
            s_axi_bready = 1'b1;
            @(negedge clock);
            lat_ok = s_axi_bvalid;
            resp = s_axi_bresp;
            @(posedge clock); #1;
            s_axi_bready = 1'b0;
        end
        $display("wr addr=%h data=%h strb=%h resp=%0d hs=%0d", addr, data, strb, resp, ok);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok, output bit lat_ok);
        @(posedge clock); #1;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        ok = 1'b0; lat_ok = 1'b0; resp = 2'b11; data = '0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_arready) ok = 1'b1;
        end
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
        if (ok) begin
            s_axi_rready = 1'b1;
            @(negedge clock);
            lat_ok = s_axi_rvalid;
            data = s_axi_rdata;
            resp = s_axi_rresp;
            @(posedge clock); #1;
            s_axi_rready = 1'b0;
        end
        $display("rd addr=%h data=%h resp=%0d hs=%0d", addr, data, resp, ok);
    endtask

    task automatic do_write(input string name, input logic [3:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp;
        bit ok, lat;
        axi_write(addr, data, strb, resp, ok, lat);
        model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        checks++;
        if (!ok || !lat || resp !== 2'b00) begin
            errors++;
            $display("FAIL %s write addr=%h: hs=%0d b_next_cycle=%0d bresp=%0d, required 1 1 0",
                     name, addr, ok, lat, resp);
        end
    endtask

    task automatic do_read(input string name, input logic [3:0] addr);
        logic [31:0] d;
        logic [1:0] resp;
        bit ok, lat;
        axi_read(addr, d, resp, ok, lat);
        checks++;
        if (!ok || !lat || resp !== 2'b00 || d !== model[addr[3:2]]) begin
            errors++;
            $display("FAIL %s read addr=%h: hs=%0d r_next_cycle=%0d rresp=%0d rdata=%h, required 1 1 0 %h",
                     name, addr, ok, lat, resp, d, model[addr[3:2]]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, pwm_out} !== 6'b0
            || s_axi_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: aw/w/b/ar/r/pwm=%b rdata=%h, required 000000 0",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, pwm_out},
                     s_axi_rdata);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) do_read("reset_regs", 4'(i * 4));
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) do_write("seq", 4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) do_read("seq", 4'(i * 4));
    endtask

    task automatic test_strobe();
        do_write("strobe_clear", 4'hC, 32'h0, 4'hF);
        do_write("strobe", 4'hC, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (model[3] !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL strobe_model: %h, required 00bb00dd", model[3]);
        end
        do_read("strobe", 4'hC);
    endtask

    task automatic test_back_to_back_bp();
        @(posedge clock); #1;
        s_axi_awaddr = 4'h8; s_axi_wdata = 32'h0000_0005; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
                errors++;
                $display("FAIL lone_aw: awready=%b wready=%b, required 0 0", s_axi_awready, s_axi_wready);
            end
            @(posedge clock); #1;
        end
        s_axi_wvalid = 1'b1;
        @(negedge clock);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL joint_hs: awready=%b wready=%b, required 1 1", s_axi_awready, s_axi_wready);
        end
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        model[2] = 32'h0000_0005;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    checks++;
                    if (s_axi_bvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL bvalid_hold: cycle %0d bvalid=%b, required 1", k, s_axi_bvalid);
                    end
                end
            end
            do_read("read_during_bp", 4'h4);
        join
        @(posedge clock); #1;
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
        @(negedge clock);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_release: bvalid=%b, required 0", s_axi_bvalid);
        end
        do_read("bp_write", 4'h8);
    endtask

    task automatic test_simultaneous();
        do_write("simul_pre", 4'hC, 32'h1111_1111, 4'hF);
        @(posedge clock); #1;
        s_axi_awaddr = 4'hC; s_axi_wdata = 32'h2222_2222; s_axi_wstrb = 4'hF;
        s_axi_araddr = 4'hC;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        @(negedge clock);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL simul_hs: awready=%b arready=%b, required 1 1", s_axi_awready, s_axi_arready);
        end
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clock);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_bvalid !== 1'b1 || s_axi_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL simul_old_value: rvalid=%b bvalid=%b rdata=%h, required 1 1 11111111",
                     s_axi_rvalid, s_axi_bvalid, s_axi_rdata);
        end
        @(posedge clock); #1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        model[3] = 32'h2222_2222;
        do_read("simul_new_value", 4'hC);
    endtask

    task automatic test_random();
        logic [3:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write("rand", a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                do_read("rand", a);
            end
        end
        for (int i = 0; i < 4; i++) do_read("rand_final", 4'(i * 4 + $urandom_range(0, 3)));
    endtask

    task automatic test_pwm_wave();
        int en, inv_on, duty7_on;
        logic e;
        do_write("pwm_off", 4'h0, 32'h0, 4'hF);
        do_write("pwm_period", 4'h4, 32'd10, 4'hF);
        do_write("pwm_duty", 4'h8, 32'd3, 4'hF);
        repeat (3) @(posedge clock);
        do_write("pwm_en", 4'h0, 32'h1, 4'hF);
        en = last_hs + 1;
        repeat (35) @(posedge clock);
        checks++;
        if (pwm_log[13'(en)] !== 1'b0) begin
            errors++;
            $display("FAIL pwm_first_cycle: pwm=%b, required 0", pwm_log[13'(en)]);
        end
        for (int x = en + 1; x < en + 31; x++) begin
            e = exp_pwm(x, en, NEVER, NEVER);
            checks++;
            if (pwm_log[13'(x)] !== e) begin
                errors++;
                $display("FAIL pwm_d3: cycle %0d pwm=%b, required %b", x - en, pwm_log[13'(x)], e);
            end
        end
        do_write("pwm_invert", 4'h0, 32'h3, 4'hF);
        inv_on = last_hs + 1;
        repeat (35) @(posedge clock);
        for (int x = inv_on; x < inv_on + 30; x++) begin
            e = exp_pwm(x, en, inv_on, NEVER);
            checks++;
            if (pwm_log[13'(x)] !== e) begin
                errors++;
                $display("FAIL pwm_invert: cycle %0d pwm=%b, required %b", x - en, pwm_log[13'(x)], e);
            end
        end
        do_write("pwm_duty7", 4'h8, 32'd7, 4'hF);
        duty7_on = last_hs + 1;
        repeat (35) @(posedge clock);
        for (int x = duty7_on; x < duty7_on + 30; x++) begin
            e = exp_pwm(x, en, inv_on, duty7_on);
            checks++;
            if (pwm_log[13'(x)] !== e) begin
                errors++;
                $display("FAIL pwm_duty_change: cycle %0d pwm=%b, required %b", x - en, pwm_log[13'(x)], e);
            end
        end
    endtask

    task automatic test_pwm_edges();
        int s;
        do_write("p0_ctrl", 4'h0, 32'h1, 4'hF);
        do_write("p0_period", 4'h4, 32'd0, 4'hF);
        repeat (15) @(posedge clock);
        s = cyc;
        repeat (22) @(posedge clock);
        for (int x = s; x < s + 20; x++) begin
            checks++;
            if (pwm_log[13'(x)] !== 1'b0) begin
                errors++;
                $display("FAIL period_zero: cycle %0d pwm=%b, required 0", x - s, pwm_log[13'(x)]);
            end
        end
        do_write("full_duty", 4'h8, 32'd12, 4'hF);
        do_write("full_period", 4'h4, 32'd10, 4'hF);
        repeat (12) @(posedge clock);
        s = cyc;
        repeat (22) @(posedge clock);
        for (int x = s; x < s + 20; x++) begin
            checks++;
            if (pwm_log[13'(x)] !== 1'b1) begin
                errors++;
                $display("FAIL duty_ge_period: cycle %0d pwm=%b, required 1", x - s, pwm_log[13'(x)]);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        @(posedge clock); #1;
        s_axi_awaddr = 4'hC; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clock);
        checks++;
        if (s_axi_bvalid !== 1'b1 || pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: bvalid=%b pwm=%b, required 1 1", s_axi_bvalid, pwm_out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || pwm_out !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: bvalid=%b pwm=%b rvalid=%b rdata=%h, required 0 0 0 0",
                     s_axi_bvalid, pwm_out, s_axi_rvalid, s_axi_rdata);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        for (int i = 0; i < 4; i++) do_read("post_reset", 4'(i * 4));
        @(negedge clock);
        checks++;
        if (pwm_out !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: pwm=%b bvalid=%b, required 0 0", pwm_out, s_axi_bvalid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_strobe();
        test_back_to_back_bp();
        test_simultaneous();
        test_random();
        test_pwm_wave();
        test_pwm_edges();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
